// File: rtl/ascii_preprocessor.sv
// Source-byte normaliser feeding the token interpreters: filter FSM, FIFO, registered output stage.
// Optional build macro COMMENT_STRIP_EN enables '#'/';' comment stripping.
module ascii_preprocessor #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     uart_valid,
  input  logic [7:0]               uart_byte,
  input  logic                     stall_in,
  output logic                     valid_data,
  output logic [7:0]               incoming_ascii,
  output logic [CNT_W-1:0]         line_count,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow_flag
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_CR  = 8'h0d;
  localparam logic [7:0] CH_NL  = 8'h0a;
`ifdef COMMENT_STRIP_EN
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_SEMI = 8'h3b;

  typedef enum logic [1:0] {ST_LINE_START, ST_TEXT, ST_SPACE, ST_COMMENT} state_t;
`else
  typedef enum logic [1:0] {ST_LINE_START, ST_TEXT, ST_SPACE} state_t;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_push;
  logic [7:0]        w_push_byte;
  logic [7:0]        w_fold;
  logic              w_is_ws;
  logic              w_is_cr;
  logic              w_is_nl;
`ifdef COMMENT_STRIP_EN
  logic              w_is_cmt;
`endif

  logic [7:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_valid;
  logic [7:0]        r_ascii;
  logic [CNT_W-1:0]  r_line_cnt;
  logic              r_ovf;
  logic              w_pop;
  logic              w_full;
  logic              w_wr;
  logic              w_drop;

  assign w_is_ws = (uart_byte == CH_SP) || (uart_byte == CH_TAB);
  assign w_is_cr = (uart_byte == CH_CR);
  assign w_is_nl = (uart_byte == CH_NL);
`ifdef COMMENT_STRIP_EN
  assign w_is_cmt = (uart_byte == CH_HASH) || (uart_byte == CH_SEMI);
`endif
  assign w_fold  = ((uart_byte >= 8'h41) && (uart_byte <= 8'h5a)) ? uart_byte + 8'h20 : uart_byte;

  // Filter FSM: decides whether the sampled byte is pushed and what it becomes
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_byte = w_fold;
    if (uart_valid) begin
      case (r_state)
        ST_LINE_START: begin
          if (w_is_nl) begin
            w_push = 1'b1;
          end else if (w_is_ws || w_is_cr) begin
            w_push = 1'b0;
`ifdef COMMENT_STRIP_EN
          end else if (w_is_cmt) begin
            w_state_nxt = ST_COMMENT;
`endif
          end else begin
            w_push      = 1'b1;
            w_state_nxt = ST_TEXT;
          end
        end
        ST_TEXT: begin
          if (w_is_ws) begin
            w_push      = 1'b1;
            w_push_byte = CH_SP;
            w_state_nxt = ST_SPACE;
          end else if (w_is_nl) begin
            w_push      = 1'b1;
            w_state_nxt = ST_LINE_START;
`ifdef COMMENT_STRIP_EN
          end else if (w_is_cmt) begin
            w_state_nxt = ST_COMMENT;
`endif
          end else if (!w_is_cr) begin
            w_push = 1'b1;
          end
        end
        ST_SPACE: begin
          if (w_is_nl) begin
            w_push      = 1'b1;
            w_state_nxt = ST_LINE_START;
          end else if (w_is_ws || w_is_cr) begin
            w_push = 1'b0;
`ifdef COMMENT_STRIP_EN
          end else if (w_is_cmt) begin
            w_state_nxt = ST_COMMENT;
`endif
          end else begin
            w_push      = 1'b1;
            w_state_nxt = ST_TEXT;
          end
        end
`ifdef COMMENT_STRIP_EN
        ST_COMMENT: begin
          if (w_is_nl) begin
            w_push      = 1'b1;
            w_state_nxt = ST_LINE_START;
          end
        end
`endif
        default: w_state_nxt = ST_LINE_START;
      endcase
    end
  end

  // Full FIFO still accepts a push when a pop frees the slot on the same edge
  assign w_pop  = (r_count != '0) && !stall_in;
  assign w_full = (r_count == CW'(DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= ST_LINE_START;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_ascii    <= 8'h00;
      r_line_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_drop) r_ovf <= 1'b1;
      r_valid <= w_pop;
      if (w_pop) begin
        r_ascii <= r_mem[r_rd_ptr];
        if (r_mem[r_rd_ptr] == CH_NL) r_line_cnt <= r_line_cnt + CNT_W'(1);
      end
    end
  end

  // Storage array carries no reset; only the pointers define its contents
  always_ff @(posedge clk_in) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_byte;
  end

  assign valid_data     = r_valid;
  assign incoming_ascii = r_ascii;
  assign line_count     = r_line_cnt;
  assign fifo_count     = r_count;
  assign overflow_flag  = r_ovf;

endmodule

// File: tb/tb_ascii_preprocessor.sv
// Self-checking bench for ascii_preprocessor: directed cases plus random byte streams
// compared against a line-oriented reference model.
module tb_ascii_preprocessor;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              uart_valid;
  logic [7:0]        uart_byte;
  logic              stall_in;
  logic              valid_data;
  logic [7:0]        incoming_ascii;
  logic [CNT_W-1:0]  line_count;
  logic [4:0]        fifo_count;
  logic              overflow_flag;

  int n_err = 0;
  int n_chk = 0;
  int exp_lines = 0;
  logic [7:0] q_in[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  ascii_preprocessor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .uart_valid(uart_valid), .uart_byte(uart_byte),
    .stall_in(stall_in), .valid_data(valid_data), .incoming_ascii(incoming_ascii),
    .line_count(line_count), .fifo_count(fifo_count), .overflow_flag(overflow_flag)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (valid_data === 1'b1) got.push_back(incoming_ascii);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    uart_valid = 1'b1;
    uart_byte  = b;
    q_in.push_back(b);
    if (b == 8'h0a) exp_lines++;
    cycle();
    uart_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    cycle();
    rst_in = 1'b1;
    exp_lines = 0;
    q_in.delete();
    got.delete();
  endtask

  task automatic begin_scn();
    q_in.delete();
    got.delete();
  endtask

  task automatic drain(input string tag);
    stall_in = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fifo_count == 5'd0) break;
      cycle();
    end
    cycle();
    cycle();
    check({tag, "_drained"}, 32'(fifo_count), 32'd0);
  endtask

  // Reference: CR is invisible, each line is comment-cut, trimmed on the left,
  // whitespace runs become one space, letters lowercased.
  function automatic void emit_line(input logic [7:0] l[$]);
    bit pending = 0;
    bit started = 0;
    for (int i = 0; i < l.size(); i++) begin
      logic [7:0] c;
      c = l[i];
`ifdef COMMENT_STRIP_EN
      if (c == 8'h23 || c == 8'h3b) break;
`endif
      if (c == 8'h20 || c == 8'h09) begin
        if (started) pending = 1;
      end else begin
        if (pending) exp_q.push_back(8'h20);
        pending = 0;
        started = 1;
        exp_q.push_back((c >= 8'h41 && c <= 8'h5a) ? c + 8'h20 : c);
      end
    end
    if (pending) exp_q.push_back(8'h20);
  endfunction

  function automatic void build_exp();
    logic [7:0] line[$];
    exp_q.delete();
    for (int i = 0; i < q_in.size(); i++) begin
      if (q_in[i] == 8'h0d) continue;
      if (q_in[i] == 8'h0a) begin
        emit_line(line);
        exp_q.push_back(8'h0a);
        line.delete();
      end else begin
        line.push_back(q_in[i]);
      end
    end
    emit_line(line);
  endfunction

  task automatic cmp_stream(input string tag);
    build_exp();
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check(tag, 32'(got[i]), 32'(exp_q[i]));
    check({tag, "_lines"}, 32'(line_count), 32'(CNT_W'(exp_lines)));
  endtask

  function automatic logic [7:0] rnd_char();
    case ($urandom_range(0, 11))
      0, 1, 2: return 8'($urandom_range(8'h61, 8'h7a));
      3, 4:    return 8'($urandom_range(8'h41, 8'h5a));
      5:       return 8'h20;
      6:       return 8'h09;
      7:       return 8'h0d;
      8:       return 8'h0a;
      9:       return ($urandom_range(0, 1) == 0) ? 8'h23 : 8'h3b;
      10:      return 8'($urandom_range(8'h30, 8'h39));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    rst_in = 1'b0; uart_valid = 1'b0; uart_byte = 8'h00; stall_in = 1'b0;
    cycle();
    do_reset();
    check("rst_valid", 32'(valid_data), 32'd0);
    check("rst_ascii", 32'(incoming_ascii), 32'h00);
    check("rst_lines", 32'(line_count), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow_flag), 32'd0);

    // Case 1 with latency probe on the first pushed byte
    begin_scn();
    send_str("  ");
    send("A");
    check("lat_edge_k_valid", 32'(valid_data), 32'd0);
    check("lat_edge_k_count", 32'(fifo_count), 32'd1);
    send("D");
    check("lat_edge_k1_valid", 32'(valid_data), 32'd1);
    check("lat_edge_k1_ascii", 32'(incoming_ascii), 32'h61);
    send_str("DI X1, x0, 0xFF\r\n");
    drain("addi");
    cmp_stream("addi");
    check("addi_lines1", 32'(line_count), 32'd1);

    begin_scn();
    send_str("a \t\t b\n");
    drain("ws");
    cmp_stream("ws");

    begin_scn();
    send_str("nop # xyz;\nli\n");
    drain("cmt");
    cmp_stream("cmt");

    for (int r = 0; r < 4; r++) begin
      begin_scn();
      for (int n = 0; n < 60; n++) begin
        stall_in = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) cycle();
        send(rnd_char());
      end
      send(8'h0a);
      drain("rnd");
      cmp_stream("rnd");
      check("rnd_ovf", 32'(overflow_flag), 32'd0);
    end

    // Overflow under stall, then a contiguous 16-byte burst on release
    begin_scn();
    stall_in = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) send("a");
    check("ovf_count", 32'(fifo_count), 32'd16);
    check("ovf_flag", 32'(overflow_flag), 32'd1);
    stall_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("burst_valid", 32'(valid_data), (i < 16) ? 32'd1 : 32'd0);
      check("burst_ascii", 32'(incoming_ascii), 32'h61);
    end
    check("burst_count", 32'(fifo_count), 32'd0);

    // Simultaneous push and pop on a full FIFO
    do_reset();
    stall_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) send("b");
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_ovf", 32'(overflow_flag), 32'd0);
    stall_in = 1'b0;
    send("c");
    check("pp_count", 32'(fifo_count), 32'd16);
    check("pp_ovf", 32'(overflow_flag), 32'd0);
    check("pp_valid", 32'(valid_data), 32'd1);
    check("pp_ascii", 32'(incoming_ascii), 32'h62);
    drain("pp");
    cmp_stream("pp");
    check("pp_ovf_end", 32'(overflow_flag), 32'd0);

    // Reset mid-stream discards buffered bytes
    stall_in = 1'b1;
    send_str("abc");
    check("mid_count", 32'(fifo_count), 32'd3);
    do_reset();
    check("mrst_count", 32'(fifo_count), 32'd0);
    check("mrst_valid", 32'(valid_data), 32'd0);
    check("mrst_lines", 32'(line_count), 32'd0);
    stall_in = 1'b0;
    begin_scn();
    send_str("x\n");
    drain("post");
    cmp_stream("post");
    check("post_lines1", 32'(line_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
